pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Parametrised next-PC unit for the MIPS single-cycle datapath. It supersedes the 2:1 next-PC select with a registered program counter and a full next-PC selector. It computes sequential, beq/bne branch, j, jr and exception targets, and holds the PC under stall. A redirect that arrives while stalled is buffered and applied when the stall releases. It feeds instruction memory directly and drives `pc_plus4` to the datapath.

## Interface
- `WIDTH`, 32, address width; must be ≥ 32.
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset (WIDTH bits).
- `EXC_VECTOR`, 32'h0000_0180, target for exceptions and jr alignment errors (WIDTH bits).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `stall`  in  1  hold PC this cycle.
- `branch`  in  1  beq decoded.
- `branch_ne`  in  1  bne decoded.
- `zero`  in  1  ALU zero flag.
- `imm`  in  16  branch offset in words, signed.
- `jump`  in  1  j decoded.
- `jump_index`  in  26  j instruction index field.
- `jump_reg`  in  1  jr decoded.
- `reg_target`  in  WIDTH  jr target from register file.
- `exception`  in  1  exception request.
- `pc`  out  WIDTH  registered program counter.
- `pc_plus4`  out  WIDTH  combinational `pc + 4`, modulo 2^WIDTH.
- `redirect`  out  1  registered; high for 1 cycle after any non-sequential PC load.
- `addr_err`  out  1  registered, sticky; set by a misaligned jr.

## Operation
- `taken = (branch & zero) | (branch_ne & ~zero)`.
- Branch target = `pc_plus4 + (sext(imm) << 2)`, truncated to WIDTH (wraps).
- Jump target = `{pc_plus4[WIDTH-1:28], jump_index, 2'b00}`.
- jr target = `reg_target`. If `reg_target[1:0] != 0`, the target becomes `EXC_VECTOR` and `addr_err` sets.
- Priority, highest first: `exception` > `jump_reg` > `jump` > `taken` > sequential (`pc_plus4`).
- A request is any of exception, jump_reg, jump or taken. The selected non-sequential target is `req_target`.
- Internal pending buffer: `pend_valid` (1 bit) and `pend_target` (WIDTH bits).
- States:
  - RUN (`pend_valid=0`)
  - HELD (`pend_valid=1`)
- RUN, `stall=0`:
  - `pc <= request ? req_target : pc_plus4`.
  - `redirect <= request`.
- RUN, `stall=1`:
  - `pc` holds and `redirect <= 0`.
  - If request: `pend_target <= req_target`, go to HELD.
- HELD, `stall=1`:
  - `pc` holds and `redirect <= 0`.
  - A new request overwrites `pend_target`; the last request wins.
- HELD, `stall=0`:
  - If `exception`: `pc <= EXC_VECTOR`.
  - Otherwise: `pc <= pend_target`.
  - In both cases `redirect <= 1`, `pend_valid <= 0`, return to RUN.
  - Other same-cycle requests are ignored.
- `exception` while stalled is captured into the pending buffer like any other request.
- `addr_err` sets on any cycle where `jump_reg` is the winning source with a misaligned target, stalled or not. Only reset clears it.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - `pc = RESET_VECTOR`, `redirect = 0`, `addr_err = 0`, `pend_valid = 0`.
  - Reset overrides stall, pending and all requests, including mid-stall with a pending redirect.
- `pc` updates on the rising edge. Next-PC selection is combinational from the current-cycle inputs. Latency is 1 cycle from control inputs to `pc`.
- `pc_plus4` follows `pc` combinationally. `pc = 2^WIDTH-4` gives `pc_plus4 = 0`.
- The first cycle after reset release, `pc = RESET_VECTOR` and `redirect = 0`.
- Stall hold is unbounded. No request is lost across any stall length.

## Test plan
- Reset then 3 free-running cycles: `pc` = 0x0, 0x4, 0x8, 0xC; `redirect` = 0 throughout.
- Branches at `pc`=0x100:
  - beq, `zero=1`, `imm`=16'hFFFE: next `pc` = 0xFC, `redirect`=1 for one cycle.
  - bne, `zero=1`: next `pc` = 0x104.
- Priority: `pc`=0x0040_0000 with `jump=1`, `jump_index`=26'h10, and `taken=1` simultaneously: `pc` = 0x0000_0040. Adding `exception=1` gives `pc` = 0x180.
- Stalled redirect:
  - `stall=1` for 3 cycles, jr to 0x2000 presented in cycle 1, j to 0x40 in cycle 2: `pc` holds throughout.
  - On release: `pc` = 0x40, `redirect`=1.
  - Repeat with `exception=1` in the release cycle: `pc` = 0x180.
- Misaligned jr, `reg_target`=0x1002: `pc` = 0x180. `addr_err`=1 and stays 1 across 10 further cycles until `rst_n=0`.
- Edge cases:
  - `pc`=0xFFFF_FFFC sequential: `pc` wraps to 0x0.
  - `rst_n=0` asserted during stall with `pend_valid`: `pc` = RESET_VECTOR, and the pending target is never applied.

Source files
------------

// File: rtl/pc_next_unit_if.sv
// rtl/pc_next_unit_if.sv - control and PC bundle between decode/datapath and the next-PC unit
interface pc_next_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             branch;
    logic             branch_ne;
    logic             zero;
    logic [15:0]      imm;
    logic             jump;
    logic [25:0]      jump_index;
    logic             jump_reg;
    logic [WIDTH-1:0] reg_target;
    logic             exception;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             redirect;
    logic             addr_err;

    modport master (
        output stall, branch, branch_ne, zero, imm, jump, jump_index,
               jump_reg, reg_target, exception,
        input  pc, pc_plus4, redirect, addr_err
    );

    modport slave (
        input  stall, branch, branch_ne, zero, imm, jump, jump_index,
               jump_reg, reg_target, exception,
        output pc, pc_plus4, redirect, addr_err
    );
endinterface

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - registered PC with branch/jump/jr/exception select and stall-buffered redirect
module pc_next_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_next_unit_if.slave  bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             redirect_q, redirect_d;
    logic             addr_err_q, addr_err_d;
    logic [0:0]       pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] req_target;
    logic             taken;
    logic             jr_misaligned;
    logic             request;

    assign pc_plus4  = pc_q + {{(WIDTH-3){1'b0}}, 3'b100};
    assign taken     = (bus.branch & bus.zero) | (bus.branch_ne & ~bus.zero);
    assign br_target = pc_plus4 + {{(WIDTH-18){bus.imm[15]}}, bus.imm, 2'b00};
    assign j_target  = {pc_plus4[WIDTH-1:28], bus.jump_index, 2'b00};

    // A misaligned jr is diverted to the exception vector rather than fetched.
    assign jr_misaligned = (bus.reg_target[1:0] != 2'b00);
    assign jr_target     = jr_misaligned ? EXC_VECTOR : bus.reg_target;

    assign request = bus.exception | bus.jump_reg | bus.jump | taken;

    always_comb begin
        req_target = br_target;
        if (bus.exception) begin
            req_target = EXC_VECTOR;
        end else if (bus.jump_reg) begin
            req_target = jr_target;
        end else if (bus.jump) begin
            req_target = j_target;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        redirect_d    = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        addr_err_d    = addr_err_q | (bus.jump_reg & ~bus.exception & jr_misaligned);

        if (pend_valid_q == RUN) begin
            if (!bus.stall) begin
                pc_d       = request ? req_target : pc_plus4;
                redirect_d = request;
            end else if (request) begin
                pend_target_d = req_target;
                pend_valid_d  = HELD;
            end
        end else begin
            if (bus.stall) begin
                if (request) begin
                    pend_target_d = req_target;
                end
            end else begin
                // Release: only an exception can pre-empt the buffered target.
                pc_d         = bus.exception ? EXC_VECTOR : pend_target_q;
                redirect_d   = 1'b1;
                pend_valid_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            redirect_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            pend_valid_q  <= RUN;
            pend_target_q <= RESET_VECTOR;
        end else begin
            pc_q          <= pc_d;
            redirect_q    <= redirect_d;
            addr_err_q    <= addr_err_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.redirect = redirect_q;
    assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - scoreboard bench for pc_next_unit
module tb_pc_next_unit;
    logic clk;
    logic rst_n;

    pc_next_unit_if #(.WIDTH(32)) bus ();

    pc_next_unit #(
        .WIDTH(32),
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR(32'h0000_0180)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        redir;
    } exp_t;

    typedef struct packed {
        logic        stall;
        logic        branch;
        logic        branch_ne;
        logic        zero;
        logic [15:0] imm;
        logic        jump;
        logic [25:0] jump_index;
        logic        jump_reg;
        logic [31:0] reg_target;
        logic        exception;
        logic [31:0] exp_pc;
        logic        exp_redir;
    } stim_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic stim_t mk(input logic st, input logic br, input logic bne, input logic z,
                                 input logic [15:0] im, input logic j, input logic [25:0] ji,
                                 input logic jr, input logic [31:0] rt, input logic exc,
                                 input logic [31:0] epc, input logic erd);
        stim_t s;
        s.stall = st; s.branch = br; s.branch_ne = bne; s.zero = z; s.imm = im;
        s.jump = j; s.jump_index = ji; s.jump_reg = jr; s.reg_target = rt;
        s.exception = exc; s.exp_pc = epc; s.exp_redir = erd;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input stim_t s);
        bus.stall = s.stall; bus.branch = s.branch; bus.branch_ne = s.branch_ne;
        bus.zero = s.zero; bus.imm = s.imm; bus.jump = s.jump;
        bus.jump_index = s.jump_index; bus.jump_reg = s.jump_reg;
        bus.reg_target = s.reg_target; bus.exception = s.exception;
    endtask

    task automatic idle();
        apply(mk(0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 32'h0, 0));
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        checks++;
        if (bus.pc !== 32'h0 || bus.redirect !== 1'b0 || bus.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h redirect=%b addr_err=%b required pc=0 redirect=0 addr_err=0",
                     bus.pc, bus.redirect, bus.addr_err);
        end
        checks++;
        if (bus.pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_pc_plus4 got=%h required=00000004", bus.pc_plus4);
        end
        for (int i = 1; i <= 3; i++) begin
            sb.push_back('{pc: 32'(4 * i), redir: 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.redirect !== e.redir) begin
                errors++;
                $display("FAIL free_run step %0d pc=%h redirect=%b required pc=%h redirect=%b",
                         i, bus.pc, bus.redirect, e.pc, e.redir);
            end
        end
    endtask

    task automatic test_branch();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0, 1, 32'h100, 0, 32'h100, 1));
        st.push_back(mk(0, 1, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0,   0, 32'h0FC, 1));
        st.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0, 0, 32'h0,   0, 32'h100, 0));
        st.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0, 1, 32'h100, 0, 32'h100, 1));
        st.push_back(mk(0, 0, 1, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0,   0, 32'h104, 0));
        st.push_back(mk(0, 0, 1, 0, 16'h0003, 0, 26'h0, 0, 32'h0,   0, 32'h114, 1));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back('{pc: st[i].exp_pc, redir: st[i].exp_redir});
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.redirect !== e.redir) begin
                errors++;
                $display("FAIL branch step %0d pc=%h redirect=%b required pc=%h redirect=%b",
                         i, bus.pc, bus.redirect, e.pc, e.redir);
            end
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 26'h0,  1, 32'h0040_0000, 0, 32'h0040_0000, 1));
        st.push_back(mk(0, 1, 0, 1, 16'h8, 1, 26'h10, 0, 32'h0,         0, 32'h0000_0040, 1));
        st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 26'h0,  1, 32'h0040_0000, 0, 32'h0040_0000, 1));
        st.push_back(mk(0, 1, 0, 1, 16'h8, 1, 26'h10, 1, 32'h2000,      1, 32'h0000_0180, 1));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back('{pc: st[i].exp_pc, redir: st[i].exp_redir});
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.redirect !== e.redir) begin
                errors++;
                $display("FAIL priority step %0d pc=%h redirect=%b required pc=%h redirect=%b",
                         i, bus.pc, bus.redirect, e.pc, e.redir);
            end
        end
    endtask

    task automatic test_stall_redirect();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(1, 0, 0, 0, 16'h0, 0, 26'h0,  1, 32'h2000, 0, 32'h180, 0));
        st.push_back(mk(1, 0, 0, 0, 16'h0, 1, 26'h10, 0, 32'h0,    0, 32'h180, 0));
        st.push_back(mk(1, 0, 0, 0, 16'h0, 0, 26'h0,  0, 32'h0,    0, 32'h180, 0));
        st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 26'h0,  0, 32'h0,    0, 32'h040, 1));
        st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 26'h0,  0, 32'h0,    0, 32'h044, 0));
        st.push_back(mk(1, 0, 0, 0, 16'h0, 0, 26'h0,  1, 32'h2000, 0, 32'h044, 0));
        st.push_back(mk(1, 0, 0, 0, 16'h0, 1, 26'h10, 0, 32'h0,    0, 32'h044, 0));
        st.push_back(mk(1, 0, 0, 0, 16'h0, 0, 26'h0,  0, 32'h0,    0, 32'h044, 0));
        st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 26'h0,  0, 32'h0,    1, 32'h180, 1));
        st.push_back(mk(1, 0, 0, 0, 16'h0, 0, 26'h0,  0, 32'h0,    0, 32'h180, 0));
        st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 26'h0,  0, 32'h0,    0, 32'h184, 0));
        foreach (st[i]) begin
            apply(st[i]);
            sb.push_back('{pc: st[i].exp_pc, redir: st[i].exp_redir});
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.redirect !== e.redir) begin
                errors++;
                $display("FAIL stall_redirect step %0d pc=%h redirect=%b required pc=%h redirect=%b",
                         i, bus.pc, bus.redirect, e.pc, e.redir);
            end
        end
    endtask

    task automatic test_misaligned_jr();
        exp_t e;
        apply(mk(0, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h1002, 0, 32'h0, 0));
        sb.push_back('{pc: 32'h180, redir: 1'b1});
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.redirect !== e.redir || bus.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_jr pc=%h redirect=%b addr_err=%b required pc=%h redirect=%b addr_err=1",
                     bus.pc, bus.redirect, bus.addr_err, e.pc, e.redir);
        end
        idle();
        for (int i = 1; i <= 10; i++) begin
            sb.push_back('{pc: 32'(32'h180 + 4 * i), redir: 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.addr_err !== 1'b1) begin
                errors++;
                $display("FAIL addr_err_sticky cycle %0d pc=%h addr_err=%b required pc=%h addr_err=1",
                         i, bus.pc, bus.addr_err, e.pc);
            end
        end
        do_reset();
        checks++;
        if (bus.addr_err !== 1'b0 || bus.pc !== 32'h0) begin
            errors++;
            $display("FAIL addr_err_clear addr_err=%b pc=%h required addr_err=0 pc=00000000",
                     bus.addr_err, bus.pc);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        apply(mk(0, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0));
        sb.push_back('{pc: 32'hFFFF_FFFC, redir: 1'b1});
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.redirect !== e.redir || bus.pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_load pc=%h redirect=%b pc_plus4=%h required pc=%h redirect=%b pc_plus4=00000000",
                     bus.pc, bus.redirect, bus.pc_plus4, e.pc, e.redir);
        end
        idle();
        sb.push_back('{pc: 32'h0, redir: 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.redirect !== e.redir) begin
            errors++;
            $display("FAIL wrap_seq pc=%h redirect=%b required pc=%h redirect=%b",
                     bus.pc, bus.redirect, e.pc, e.redir);
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        do_reset();
        apply(mk(1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h2000, 0, 32'h0, 0));
        tick();
        apply(mk(1, 0, 0, 0, 16'h0, 1, 26'h10, 0, 32'h0, 0, 32'h0, 0));
        rst_n = 1'b0;
        sb.push_back('{pc: 32'h0, redir: 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.redirect !== e.redir || bus.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall pc=%h redirect=%b addr_err=%b required pc=%h redirect=%b addr_err=0",
                     bus.pc, bus.redirect, bus.addr_err, e.pc, e.redir);
        end
        rst_n = 1'b1;
        idle();
        for (int i = 1; i <= 2; i++) begin
            sb.push_back('{pc: 32'(4 * i), redir: 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.redirect !== e.redir) begin
                errors++;
                $display("FAIL no_stale_pending step %0d pc=%h redirect=%b required pc=%h redirect=%b",
                         i, bus.pc, bus.redirect, e.pc, e.redir);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_branch();
        test_priority();
        test_stall_redirect();
        test_misaligned_jr();
        test_wrap();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
